// File: rtl/cr_iu_reg_wr_ctrl_pkg.sv
// Shared definitions for the IU register write controller: FSM encoding and data width.
package cr_iu_reg_wr_ctrl_pkg;

   localparam int unsigned REG_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MERGE = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/cr_iu_reg_wr_merge.sv
// Combinational byte merge: each strobed byte comes from the new data, the rest from the register.
module cr_iu_reg_wr_merge
   import cr_iu_reg_wr_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] data,
   input  logic [REG_W-1:0] dout,
   input  logic [3:0]       strb,
   output logic [REG_W-1:0] merged
);

   always_comb begin
      merged = dout;
      for (int unsigned b = 0; b < 4; b++) begin
         if (strb[b]) merged[b*8 +: 8] = data[b*8 +: 8];
      end
   end

endmodule

// File: rtl/cr_iu_reg_wr_ctrl.sv
// Write-side controller for a bank of clock-gated IU registers (read-modify-write on byte strobes).
// Define CR_IU_REG_WR_STRB_EN to enable byte strobes and the MERGE state; otherwise all writes are full-word.
module cr_iu_reg_wr_ctrl
   import cr_iu_reg_wr_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REG = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic                     forever_cpuclk,
   input  logic                     cpurst_b,
   input  logic                     req_vld,
   output logic                     req_rdy,
   input  logic                     req_write,
   input  logic [IDX_W-1:0]         req_idx,
   input  logic [REG_W-1:0]         req_data,
   input  logic [3:0]               req_strb,
   output logic                     rsp_vld,
   input  logic                     rsp_rdy,
   output logic [REG_W-1:0]         rsp_data,
   output logic                     rsp_err,
   output logic [NUM_REG-1:0]       x_write_en,
   output logic [REG_W-1:0]         write_data,
   input  logic [NUM_REG*REG_W-1:0] x_reg_dout_all
);

   state_t               state, state_nxt;
   logic [IDX_W-1:0]     idx_q;
   logic [IDX_W-1:0]     sel_idx;
   logic [REG_W-1:0]     sel_dout;
   logic [NUM_REG-1:0]   sel_onehot;
   logic                 idx_err;
   logic [3:0]           strb_eff;
   logic                 latch_en;
   logic [NUM_REG-1:0]   wen_nxt;
   logic [REG_W-1:0]     wdata_nxt;
   logic [REG_W-1:0]     rdata_nxt;
   logic                 rvld_nxt;
   logic                 rerr_nxt;

`ifdef CR_IU_REG_WR_STRB_EN
   logic [REG_W-1:0]     data_q;
   logic [3:0]           strb_q;
   logic [REG_W-1:0]     merged;

   assign strb_eff = req_strb;

   cr_iu_reg_wr_merge u_merge (
      .data   (data_q),
      .dout   (sel_dout),
      .strb   (strb_q),
      .merged (merged)
   );
`else
   logic                 unused_strb;

   assign strb_eff    = 4'hF;
   assign unused_strb = ^req_strb;
`endif

   // One index mux serves both the request in IDLE and the latched index afterwards.
   assign sel_idx = (state == ST_IDLE) ? req_idx : idx_q;
   assign idx_err = 32'(req_idx) >= NUM_REG;
   assign req_rdy = (state == ST_IDLE);

   always_comb begin
      sel_dout   = '0;
      sel_onehot = '0;
      for (int unsigned i = 0; i < NUM_REG; i++) begin
         if (sel_idx == IDX_W'(i)) begin
            sel_dout      = x_reg_dout_all[i*REG_W +: REG_W];
            sel_onehot[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      latch_en  = 1'b0;
      wen_nxt   = '0;
      wdata_nxt = write_data;
      rdata_nxt = rsp_data;
      rvld_nxt  = rsp_vld;
      rerr_nxt  = rsp_err;
      case (state)
         ST_IDLE: begin
            if (req_vld) begin
               latch_en = 1'b1;
               rerr_nxt = 1'b0;
               if (idx_err) begin
                  state_nxt = ST_RESP;
                  rvld_nxt  = 1'b1;
                  rerr_nxt  = 1'b1;
                  rdata_nxt = '0;
               end else if (!req_write) begin
                  state_nxt = ST_RESP;
                  rvld_nxt  = 1'b1;
                  rdata_nxt = sel_dout;
               end else if (strb_eff == 4'hF) begin
                  state_nxt = ST_WRITE;
                  wen_nxt   = sel_onehot;
                  wdata_nxt = req_data;
               end
`ifdef CR_IU_REG_WR_STRB_EN
               else if (strb_eff == 4'h0) begin
                  state_nxt = ST_RESP;
                  rvld_nxt  = 1'b1;
                  rdata_nxt = sel_dout;
               end else begin
                  state_nxt = ST_MERGE;
               end
`endif
            end
         end
`ifdef CR_IU_REG_WR_STRB_EN
         ST_MERGE: begin
            state_nxt = ST_WRITE;
            wen_nxt   = sel_onehot;
            wdata_nxt = merged;
         end
`endif
         // write_data already holds the merged word during WRITE
         ST_WRITE: begin
            state_nxt = ST_RESP;
            rvld_nxt  = 1'b1;
            rdata_nxt = write_data;
         end
         ST_RESP: begin
            if (rsp_rdy) begin
               state_nxt = ST_IDLE;
               rvld_nxt  = 1'b0;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state      <= ST_IDLE;
         idx_q      <= '0;
         x_write_en <= '0;
         write_data <= '0;
         rsp_vld    <= 1'b0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
      end else begin
         state      <= state_nxt;
         x_write_en <= wen_nxt;
         write_data <= wdata_nxt;
         rsp_vld    <= rvld_nxt;
         rsp_data   <= rdata_nxt;
         rsp_err    <= rerr_nxt;
         if (latch_en) idx_q <= req_idx;
      end
   end

`ifdef CR_IU_REG_WR_STRB_EN
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         data_q <= '0;
         strb_q <= '0;
      end else if (latch_en) begin
         data_q <= req_data;
         strb_q <= req_strb;
      end
   end
`endif

endmodule

// File: tb/tb_cr_iu_reg_wr_ctrl.sv
// Self-checking bench for cr_iu_reg_wr_ctrl with three attached registers and a transaction-level reference model.
module tb_cr_iu_reg_wr_ctrl;

   logic        clk = 1'b0;
   logic        cpurst_b;
   logic        req_vld, req_rdy, req_write;
   logic [1:0]  req_idx;
   logic [31:0] req_data;
   logic [3:0]  req_strb;
   logic        rsp_vld, rsp_rdy, rsp_err;
   logic [31:0] rsp_data, write_data;
   logic [2:0]  x_write_en;
   logic [95:0] x_reg_dout_all;

   logic [31:0] bank [3];
   logic [31:0] exp_regs [3];
   logic        load_en;
   logic [1:0]  load_idx;
   logic [31:0] load_val;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   cr_iu_reg_wr_ctrl #(.NUM_REG(3), .IDX_W(2)) dut (
      .forever_cpuclk (clk),
      .cpurst_b       (cpurst_b),
      .req_vld        (req_vld),
      .req_rdy        (req_rdy),
      .req_write      (req_write),
      .req_idx        (req_idx),
      .req_data       (req_data),
      .req_strb       (req_strb),
      .rsp_vld        (rsp_vld),
      .rsp_rdy        (rsp_rdy),
      .rsp_data       (rsp_data),
      .rsp_err        (rsp_err),
      .x_write_en     (x_write_en),
      .write_data     (write_data),
      .x_reg_dout_all (x_reg_dout_all)
   );

   // attached gated registers: x_write_en acts as the local clock enable
   always @(posedge clk) begin
      if (load_en) bank[load_idx] <= load_val;
      else for (int i = 0; i < 3; i++) if (x_write_en[i]) bank[i] <= write_data;
   end
   assign x_reg_dout_all = {bank[2], bank[1], bank[0]};

   task automatic preload(input logic [1:0] idx, input logic [31:0] val);
      @(negedge clk);
      load_en = 1'b1; load_idx = idx; load_val = val;
      @(negedge clk);
      load_en = 1'b0;
      exp_regs[idx] = val;
   endtask

   // Reference: outcome of one transaction computed from the register-level rules.
   task automatic model_txn(input logic w, input logic [1:0] idx, input logic [31:0] data,
                            input logic [3:0] strb, output int lat, output logic [31:0] rdata,
                            output logic rerr, output logic [2:0] wen);
      logic [3:0]  s;
      logic [31:0] v;
      s = strb;
`ifndef CR_IU_REG_WR_STRB_EN
      s = 4'hF;
`endif
      lat = 1; rdata = '0; rerr = 1'b0; wen = '0;
      if (idx >= 2'd3) rerr = 1'b1;
      else if (!w || s == 4'h0) rdata = exp_regs[idx];
      else begin
         v = exp_regs[idx];
         for (int b = 0; b < 4; b++) if (s[b]) v[b*8 +: 8] = data[b*8 +: 8];
         exp_regs[idx] = v;
         rdata = v;
         wen = 3'b001 << idx;
         lat = (s == 4'hF) ? 2 : 3;
      end
   endtask

   // Drives one request and records what the DUT did; lat = cycles from accept to rsp_vld (99 = timeout).
   task automatic run_txn(input logic w, input logic [1:0] idx, input logic [31:0] data,
                          input logic [3:0] strb, input int hold, output int lat,
                          output logic [31:0] rdata, output logic rerr, output logic [2:0] wen_val,
                          output int wen_cycles, output logic [31:0] wdata, output logic hold_ok,
                          output logic rdy_after);
      int t;
      lat = 99; rdata = '0; rerr = 1'b0; wen_val = '0; wen_cycles = 0;
      wdata = '0; hold_ok = 1'b1; rdy_after = 1'b0;
      @(negedge clk);
      req_vld = 1'b1; req_write = w; req_idx = idx; req_data = data; req_strb = strb;
      t = 0;
      while (!req_rdy && t < 20) begin @(negedge clk); t++; end
      if (!req_rdy) begin req_vld = 1'b0; return; end
      @(negedge clk);
      req_vld = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (x_write_en != 3'b000) begin wen_cycles++; wen_val |= x_write_en; wdata = write_data; end
         if (req_rdy) hold_ok = 1'b0;
         if (rsp_vld) begin lat = k; rdata = rsp_data; rerr = rsp_err; break; end
         @(negedge clk);
      end
      if (lat == 99) return;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (!rsp_vld || rsp_data !== rdata || rsp_err !== rerr || req_rdy || x_write_en != 3'b000)
            hold_ok = 1'b0;
      end
      rsp_rdy = 1'b1;
      @(negedge clk);
      rsp_rdy = 1'b0;
      rdy_after = req_rdy;
   endtask

   int          lat, wen_cycles, e_lat;
   logic [31:0] rdata, wdata, e_rdata;
   logic        rerr, hold_ok, rdy_after, e_rerr;
   logic [2:0]  wen_val, e_wen;

   task automatic test_reset();
      cpurst_b = 1'b0;
      repeat (3) @(negedge clk);
      vectors++; if (x_write_en !== 3'b000) begin miscompares++; $display("FAIL reset_wen: got %b expected 000", x_write_en); end
      vectors++; if (write_data !== 32'h0) begin miscompares++; $display("FAIL reset_wdata: got %h expected 00000000", write_data); end
      vectors++; if (rsp_vld !== 1'b0 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp: got vld %b err %b expected 0 0", rsp_vld, rsp_err); end
      vectors++; if (rsp_data !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h expected 00000000", rsp_data); end
      vectors++; if (req_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_rdy: got %b expected 1", req_rdy); end
      cpurst_b = 1'b1;
   endtask

   task automatic test_full_write();
      model_txn(1'b1, 2'd2, 32'hDEADBEEF, 4'hF, e_lat, e_rdata, e_rerr, e_wen);
      run_txn(1'b1, 2'd2, 32'hDEADBEEF, 4'hF, 0, lat, rdata, rerr, wen_val, wen_cycles, wdata, hold_ok, rdy_after);
      vectors++; if (wen_val !== 3'b100 || wen_cycles != 1) begin miscompares++; $display("FAIL full_wen: got %b x%0d expected 100 x1", wen_val, wen_cycles); end
      vectors++; if (wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL full_wdata: got %h expected deadbeef", wdata); end
      vectors++; if (lat != 2) begin miscompares++; $display("FAIL full_lat: got %0d expected 2", lat); end
      vectors++; if (rdata !== 32'hDEADBEEF || rerr !== 1'b0) begin miscompares++; $display("FAIL full_rsp: got %h/%b expected deadbeef/0", rdata, rerr); end
      vectors++; if (bank[2] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL full_reg: got %h expected deadbeef", bank[2]); end
      vectors++; if (rdy_after !== 1'b1) begin miscompares++; $display("FAIL full_rdy_after: got %b expected 1", rdy_after); end
   endtask

   task automatic test_partial_write();
      logic [31:0] exp_w;
      int          exp_l;
`ifdef CR_IU_REG_WR_STRB_EN
      exp_w = 32'h11BB33DD; exp_l = 3;
`else
      exp_w = 32'hAABBCCDD; exp_l = 2;
`endif
      preload(2'd1, 32'h11223344);
      model_txn(1'b1, 2'd1, 32'hAABBCCDD, 4'b0101, e_lat, e_rdata, e_rerr, e_wen);
      run_txn(1'b1, 2'd1, 32'hAABBCCDD, 4'b0101, 0, lat, rdata, rerr, wen_val, wen_cycles, wdata, hold_ok, rdy_after);
      vectors++; if (wdata !== exp_w) begin miscompares++; $display("FAIL partial_wdata: got %h expected %h", wdata, exp_w); end
      vectors++; if (lat != exp_l) begin miscompares++; $display("FAIL partial_lat: got %0d expected %0d", lat, exp_l); end
      vectors++; if (wen_val !== 3'b010 || wen_cycles != 1) begin miscompares++; $display("FAIL partial_wen: got %b x%0d expected 010 x1", wen_val, wen_cycles); end
      vectors++; if (bank[1] !== exp_w || rdata !== exp_w) begin miscompares++; $display("FAIL partial_reg: got %h rsp %h expected %h", bank[1], rdata, exp_w); end
   endtask

   task automatic test_read_hold();
      preload(2'd2, 32'h00C0FFEE);
      model_txn(1'b0, 2'd2, 32'h0, 4'h0, e_lat, e_rdata, e_rerr, e_wen);
      run_txn(1'b0, 2'd2, 32'h12345678, 4'hF, 5, lat, rdata, rerr, wen_val, wen_cycles, wdata, hold_ok, rdy_after);
      vectors++; if (rdata !== 32'h00C0FFEE || lat != 1) begin miscompares++; $display("FAIL read_rsp: got %h lat %0d expected 00c0ffee lat 1", rdata, lat); end
      vectors++; if (hold_ok !== 1'b1) begin miscompares++; $display("FAIL read_hold: got %b expected 1", hold_ok); end
      vectors++; if (wen_cycles != 0) begin miscompares++; $display("FAIL read_wen: got %0d expected 0", wen_cycles); end
      vectors++; if (rdy_after !== 1'b1) begin miscompares++; $display("FAIL read_rdy_after: got %b expected 1", rdy_after); end
   endtask

   task automatic test_idx_err();
      model_txn(1'b1, 2'd3, 32'hCAFEF00D, 4'hF, e_lat, e_rdata, e_rerr, e_wen);
      run_txn(1'b1, 2'd3, 32'hCAFEF00D, 4'hF, 2, lat, rdata, rerr, wen_val, wen_cycles, wdata, hold_ok, rdy_after);
      vectors++; if (rerr !== 1'b1 || rdata !== 32'h0) begin miscompares++; $display("FAIL err_rsp: got %b/%h expected 1/00000000", rerr, rdata); end
      vectors++; if (wen_cycles != 0 || lat != 1) begin miscompares++; $display("FAIL err_wen: got %0d lat %0d expected 0 lat 1", wen_cycles, lat); end
      vectors++; if (hold_ok !== 1'b1) begin miscompares++; $display("FAIL err_hold: got %b expected 1", hold_ok); end
   endtask

   task automatic test_strb_zero();
      logic [31:0] prior;
      prior = exp_regs[0];
      model_txn(1'b1, 2'd0, 32'h87654321, 4'h0, e_lat, e_rdata, e_rerr, e_wen);
      run_txn(1'b1, 2'd0, 32'h87654321, 4'h0, 0, lat, rdata, rerr, wen_val, wen_cycles, wdata, hold_ok, rdy_after);
`ifdef CR_IU_REG_WR_STRB_EN
      vectors++; if (wen_cycles != 0 || rdata !== prior) begin miscompares++; $display("FAIL strb0: got wen x%0d rsp %h expected x0 %h", wen_cycles, rdata, prior); end
`else
      vectors++; if (wen_cycles != 1 || rdata !== 32'h87654321) begin miscompares++; $display("FAIL strb0: got wen x%0d rsp %h expected x1 87654321", wen_cycles, rdata); end
`endif
      vectors++; if (bank[0] !== exp_regs[0]) begin miscompares++; $display("FAIL strb0_reg: got %h expected %h", bank[0], exp_regs[0]); end
   endtask

   task automatic test_reset_mid_write();
      @(negedge clk);
      req_vld = 1'b1; req_write = 1'b1; req_idx = 2'd0; req_data = 32'h5A5A5A5A; req_strb = 4'hF;
      @(negedge clk);
      req_vld = 1'b0;
      vectors++; if (x_write_en !== 3'b001) begin miscompares++; $display("FAIL rst_pre_wen: got %b expected 001", x_write_en); end
      cpurst_b = 1'b0;
      #1;
      vectors++; if (x_write_en !== 3'b000 || rsp_vld !== 1'b0) begin miscompares++; $display("FAIL rst_async: got wen %b vld %b expected 000 0", x_write_en, rsp_vld); end
      vectors++; if (write_data !== 32'h0) begin miscompares++; $display("FAIL rst_wdata: got %h expected 00000000", write_data); end
      @(negedge clk);
      vectors++; if (bank[0] !== exp_regs[0]) begin miscompares++; $display("FAIL rst_reg: got %h expected %h", bank[0], exp_regs[0]); end
      cpurst_b = 1'b1;
      #1;
      vectors++; if (req_rdy !== 1'b1) begin miscompares++; $display("FAIL rst_rdy: got %b expected 1", req_rdy); end
   endtask

   task automatic test_random();
      logic        w;
      logic [1:0]  idx;
      logic [31:0] data;
      logic [3:0]  strb;
      int          hold, sel;
      for (int n = 0; n < 60; n++) begin
         w = 1'($urandom_range(0, 1)); idx = 2'($urandom_range(0, 3)); data = $urandom;
         sel = $urandom_range(0, 3);
         strb = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom_range(0, 15));
         hold = $urandom_range(0, 2);
         model_txn(w, idx, data, strb, e_lat, e_rdata, e_rerr, e_wen);
         run_txn(w, idx, data, strb, hold, lat, rdata, rerr, wen_val, wen_cycles, wdata, hold_ok, rdy_after);
         vectors++; if (lat != e_lat) begin miscompares++; $display("FAIL rnd%0d_lat: got %0d expected %0d", n, lat, e_lat); end
         vectors++; if (rdata !== e_rdata || rerr !== e_rerr) begin miscompares++; $display("FAIL rnd%0d_rsp: got %h/%b expected %h/%b", n, rdata, rerr, e_rdata, e_rerr); end
         vectors++; if (wen_val !== e_wen || wen_cycles != ((e_wen != 3'b000) ? 1 : 0)) begin miscompares++; $display("FAIL rnd%0d_wen: got %b x%0d expected %b", n, wen_val, wen_cycles, e_wen); end
         vectors++; if (hold_ok !== 1'b1 || rdy_after !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_hs: got hold %b rdy %b expected 1 1", n, hold_ok, rdy_after); end
         for (int r = 0; r < 3; r++) begin
            vectors++; if (bank[r] !== exp_regs[r]) begin miscompares++; $display("FAIL rnd%0d_reg%0d: got %h expected %h", n, r, bank[r], exp_regs[r]); end
         end
      end
   endtask

   initial begin
      req_vld = 1'b0; req_write = 1'b0; req_idx = '0; req_data = '0; req_strb = '0;
      rsp_rdy = 1'b0; load_en = 1'b0; load_idx = '0; load_val = '0;
      test_reset();
      preload(2'd0, 32'h01020304);
      preload(2'd1, 32'h0);
      preload(2'd2, 32'h0);
      test_full_write();
      test_partial_write();
      test_read_hold();
      test_idx_err();
      test_strb_zero();
      test_reset_mid_write();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
